// File: rtl/decode_queue_pkg.sv
// Shared decode types for the fetch/execute decode stage: instruction view,
// control word layout, queue entry, exception codes and the opcode table.
package def;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned CTRL_W  = 31;
  // Stored PC width; the queue's PC_W parameter must not exceed this.
  localparam int unsigned DQ_PC_W = 32;

  // Instruction word, R-type field view (I/J immediates overlay rd/sa/fcode).
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;
    logic [5:0] fcode;
  } c_inst;

  // Decoded control word, 31 bits, MSB first.
  typedef struct packed {
    logic [4:0] aluop;  // [30:26]
    logic [1:0] rd;     // [25:24] destination select
    logic [1:0] am;     // [23:22] ALU A source
    logic [1:0] ab;     // [21:20] ALU B source
    logic [2:0] ime;    // [19:17] immediate / multiply mode
    logic [2:0] mem;    // [16:14] memory op
    logic [1:0] wb;     // [13:12] writeback source
    logic [2:0] brt;    // [11:9]  branch type
    logic [1:0] je;     // [8:7]   jump kind
    logic [3:0] pisb;   // [6:3]   privileged: eret/ri/syscall/break
    logic [2:0] hilo;   // [2:0]   HI/LO accumulate op
  } ctrl;

  // Field positions within the packed control word.
  localparam int unsigned PISB_LSB = 3;
  localparam int unsigned PISB_W   = 4;
  localparam int unsigned JE_LSB   = 7;
  localparam int unsigned JE_W     = 2;
  localparam int unsigned BRT_LSB  = 9;
  localparam int unsigned BRT_W    = 3;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_RI   = 2'b01,
    EXC_SYS  = 2'b10,
    EXC_BRK  = 2'b11
  } exc_t;

  typedef struct packed {
    ctrl                 ctl;
    c_inst               inst;
    logic [DQ_PC_W-1:0]  pc;
    exc_t                exc;
    logic                bd;
  } dq_entry_t;

  // Opcodes
  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_JAL      = 6'b000011;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_COP0     = 6'b010000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;

  // Function codes
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_BREAK   = 6'b001101;
  localparam logic [5:0] FN_ERET    = 6'b011000;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;
  localparam logic [5:0] FN2_MADD   = 6'b000000;
  localparam logic [5:0] FN2_MADDU  = 6'b000001;

  localparam logic [4:0] RS_MFC0  = 5'b00000;
  localparam logic [4:0] RS_MTC0  = 5'b00100;
  localparam logic [4:0] RS_CO    = 5'b10000;
  localparam logic [4:0] RT_BLTZ  = 5'b00000;
  localparam logic [4:0] RT_BGEZ  = 5'b00001;

  // Control field encodings
  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_AND = 5'd2,  ALU_OR = 5'd3;
  localparam logic [4:0] ALU_XOR = 5'd4,  ALU_NOR = 5'd5,  ALU_SLT = 5'd6,  ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL = 5'd8,  ALU_SRL = 5'd9,  ALU_SRA = 5'd10, ALU_LUI = 5'd11;
  localparam logic [4:0] ALU_MADD = 5'd12, ALU_MADDU = 5'd13;

  localparam logic [1:0] RD_NONE = 2'b00, RD_RD = 2'b01, RD_RT = 2'b10, RD_R31 = 2'b11;
  localparam logic [1:0] AM_ZERO = 2'b00, AM_RS = 2'b01, AM_SA = 2'b10, AM_PC = 2'b11;
  localparam logic [1:0] AB_IMM = 2'b00, AB_RT = 2'b01, AB_FOUR = 2'b10;
  localparam logic [2:0] IME_NONE = 3'b000, IME_SEXT = 3'b001, IME_ZEXT = 3'b010;
  localparam logic [2:0] IME_LUI = 3'b011, IME_MAC = 3'b100;
  localparam logic [2:0] MEM_LW = 3'b001, MEM_SW = 3'b010;
  localparam logic [1:0] WB_ALU = 2'b01, WB_MEM = 2'b10, WB_COP0 = 2'b11;
  localparam logic [2:0] BRT_BEQ = 3'd1, BRT_BNE = 3'd2, BRT_BLTZ = 3'd3, BRT_BGEZ = 3'd4;
  localparam logic [1:0] JE_IMM = 2'b01, JE_REG = 2'b10;
  localparam logic [3:0] PISB_ERET = 4'b1000, PISB_RI = 4'b0100;
  localparam logic [3:0] PISB_SYS = 4'b0010, PISB_BRK = 4'b0001;
  localparam logic [2:0] HILO_MADD = 3'b001, HILO_MADDU = 3'b010;

  // Register-register ALU operation writing rd.
  function automatic ctrl r_alu(input logic [4:0] op);
    ctrl c;
    c       = '0;
    c.aluop = op;
    c.rd    = RD_RD;
    c.am    = AM_RS;
    c.ab    = AB_RT;
    c.wb    = WB_ALU;
    return c;
  endfunction

  // Register-immediate ALU operation writing rt.
  function automatic ctrl i_alu(input logic [4:0] op, input logic [2:0] ime);
    ctrl c;
    c       = '0;
    c.aluop = op;
    c.rd    = RD_RT;
    c.am    = AM_RS;
    c.ab    = AB_IMM;
    c.ime   = ime;
    c.wb    = WB_ALU;
    return c;
  endfunction

  // Conditional branch comparing rs against rt (or zero).
  function automatic ctrl br(input logic [2:0] brt);
    ctrl c;
    c       = '0;
    c.aluop = ALU_SUB;
    c.am    = AM_RS;
    c.ab    = AB_RT;
    c.ime   = IME_SEXT;
    c.brt   = brt;
    return c;
  endfunction

  // Exception code carried with an entry; ERET and ordinary words give none.
  function automatic exc_t pisb_to_exc(input logic [PISB_W-1:0] pisb);
    exc_t e;
    e = EXC_NONE;
    case (pisb)
      PISB_RI:  e = EXC_RI;
      PISB_SYS: e = EXC_SYS;
      PISB_BRK: e = EXC_BRK;
      default:  e = EXC_NONE;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/decode_queue_dec.sv
// Combinational opcode/FCODE/RT/RS decode table. Anything not listed decodes
// to the not-implemented word. SPECIAL2 multiply-accumulate is decoded only
// when DEC_SPECIAL2_EN is defined.
module dec_table
  import def::*;
(
  input  c_inst inst,
  output ctrl   ctl_c
);

  // rd/sa are datapath operands, not decode selectors
  logic unused_fields_c;
  assign unused_fields_c = ^{inst.rd, inst.sa};

  // Opcode table lookup, not-implemented by default
  always_comb begin
    ctl_c      = '0;
    ctl_c.pisb = PISB_RI;
    case (inst.op)
      OP_SPECIAL: begin
        case (inst.fcode)
          FN_ADD, FN_ADDU: ctl_c = r_alu(ALU_ADD);
          FN_SUB, FN_SUBU: ctl_c = r_alu(ALU_SUB);
          FN_AND:          ctl_c = r_alu(ALU_AND);
          FN_OR:           ctl_c = r_alu(ALU_OR);
          FN_XOR:          ctl_c = r_alu(ALU_XOR);
          FN_NOR:          ctl_c = r_alu(ALU_NOR);
          FN_SLT:          ctl_c = r_alu(ALU_SLT);
          FN_SLTU:         ctl_c = r_alu(ALU_SLTU);
          FN_SLL: begin ctl_c = r_alu(ALU_SLL); ctl_c.am = AM_SA; end
          FN_SRL: begin ctl_c = r_alu(ALU_SRL); ctl_c.am = AM_SA; end
          FN_SRA: begin ctl_c = r_alu(ALU_SRA); ctl_c.am = AM_SA; end
          FN_JR: begin
            ctl_c    = '0;
            ctl_c.am = AM_RS;
            ctl_c.je = JE_REG;
          end
          FN_JALR: begin
            ctl_c    = '0;
            ctl_c.rd = RD_RD;
            ctl_c.am = AM_PC;
            ctl_c.ab = AB_FOUR;
            ctl_c.wb = WB_ALU;
            ctl_c.je = JE_REG;
          end
          FN_SYSCALL: begin ctl_c = '0; ctl_c.pisb = PISB_SYS; end
          FN_BREAK:   begin ctl_c = '0; ctl_c.pisb = PISB_BRK; end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (inst.rt)
          RT_BLTZ: ctl_c = br(BRT_BLTZ);
          RT_BGEZ: ctl_c = br(BRT_BGEZ);
          default: ;
        endcase
      end
      OP_J: begin ctl_c = '0; ctl_c.je = JE_IMM; end
      OP_JAL: begin
        ctl_c    = '0;
        ctl_c.rd = RD_R31;
        ctl_c.am = AM_PC;
        ctl_c.ab = AB_FOUR;
        ctl_c.wb = WB_ALU;
        ctl_c.je = JE_IMM;
      end
      OP_BEQ:   ctl_c = br(BRT_BEQ);
      OP_BNE:   ctl_c = br(BRT_BNE);
      OP_ADDI, OP_ADDIU: ctl_c = i_alu(ALU_ADD, IME_SEXT);
      OP_SLTI:  ctl_c = i_alu(ALU_SLT, IME_SEXT);
      OP_SLTIU: ctl_c = i_alu(ALU_SLTU, IME_SEXT);
      OP_ANDI:  ctl_c = i_alu(ALU_AND, IME_ZEXT);
      OP_ORI:   ctl_c = i_alu(ALU_OR, IME_ZEXT);
      OP_XORI:  ctl_c = i_alu(ALU_XOR, IME_ZEXT);
      OP_LUI:   ctl_c = i_alu(ALU_LUI, IME_LUI);
      OP_LW: begin
        ctl_c     = i_alu(ALU_ADD, IME_SEXT);
        ctl_c.mem = MEM_LW;
        ctl_c.wb  = WB_MEM;
      end
      OP_SW: begin
        ctl_c     = i_alu(ALU_ADD, IME_SEXT);
        ctl_c.rd  = RD_NONE;
        ctl_c.wb  = 2'b00;
        ctl_c.mem = MEM_SW;
      end
      OP_COP0: begin
        case (inst.rs)
          RS_MFC0: begin
            ctl_c    = '0;
            ctl_c.rd = RD_RT;
            ctl_c.wb = WB_COP0;
          end
          RS_MTC0: begin
            ctl_c    = '0;
            ctl_c.ab = AB_RT;
          end
          RS_CO: begin
            if (inst.fcode == FN_ERET) begin
              ctl_c      = '0;
              ctl_c.pisb = PISB_ERET;
            end
          end
          default: ;
        endcase
      end
`ifdef DEC_SPECIAL2_EN
      OP_SPECIAL2: begin
        if (inst.fcode == FN2_MADD || inst.fcode == FN2_MADDU) begin
          ctl_c       = '0;
          ctl_c.aluop = (inst.fcode == FN2_MADD) ? ALU_MADD : ALU_MADDU;
          ctl_c.rd    = RD_RD;
          ctl_c.am    = AM_RS;
          ctl_c.ab    = AB_RT;
          ctl_c.ime   = IME_MAC;
          ctl_c.hilo  = (inst.fcode == FN2_MADD) ? HILO_MADD : HILO_MADDU;
        end
      end
`else
      OP_SPECIAL2: ctl_c.pisb = PISB_RI;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Decode stage between fetch and execute: decodes each accepted word once and
// buffers {ctrl, inst, pc, exc, bd} in a DEPTH-entry circular queue with
// valid/ready on both sides and a synchronous flush.
// Optional feature macro: DEC_SPECIAL2_EN (SPECIAL2 MADD/MADDU decode).
module decode_queue
  import def::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output ctrl                          out_ctrl,
  output logic [31:0]                  out_inst,
  output logic [PC_W-1:0]              out_pc,
  output logic [1:0]                   out_exc,
  output logic                         out_bd,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  dq_entry_t          mem_q [DEPTH];
  dq_entry_t          mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               bd_pend_q, bd_pend_d;

  c_inst              in_inst_c;
  ctrl                dec_ctl_c;
  logic [CTRL_W-1:0]  dec_vec_c;
  logic               dec_xfer_c;
  dq_entry_t          new_entry_c;
  dq_entry_t          head_c;
  logic               push_c;
  logic               pop_c;

  assign in_inst_c = c_inst'(in_inst);

  dec_table u_dec_table (
    .inst  (in_inst_c),
    .ctl_c (dec_ctl_c)
  );

  // Incoming word plus its delay-slot status, ready to be written
  always_comb begin
    dec_vec_c        = dec_ctl_c;
    dec_xfer_c       = (dec_vec_c[BRT_LSB +: BRT_W] != '0) || (dec_vec_c[JE_LSB +: JE_W] != '0);
    new_entry_c      = '0;
    new_entry_c.ctl  = dec_ctl_c;
    new_entry_c.inst = in_inst_c;
    new_entry_c.pc   = DQ_PC_W'(in_pc);
    new_entry_c.exc  = pisb_to_exc(dec_vec_c[PISB_LSB +: PISB_W]);
    new_entry_c.bd   = bd_pend_q;
  end

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid && in_ready && !flush;
  assign pop_c     = out_valid && out_ready && !flush;

  // Next-state for storage, pointers, occupancy and delay-slot tracking
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    bd_pend_d = bd_pend_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      bd_pend_d = 1'b0;
    end else begin
      if (push_c) begin
        mem_d[wr_ptr_q] = new_entry_c;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        bd_pend_d       = dec_xfer_c;
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers, storage cleared on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bd_pend_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bd_pend_q <= bd_pend_d;
    end
  end

  // Head entry straight from storage; meaningless while empty
  assign head_c   = mem_q[rd_ptr_q];
  assign out_ctrl = head_c.ctl;
  assign out_inst = head_c.inst;
  assign out_pc   = PC_W'(head_c.pc);
  assign out_exc  = head_c.exc;
  assign out_bd   = head_c.bd;
  assign count    = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEPTH=4, PC_W=32).
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_ctrl;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [1:0]  out_exc;
  logic        out_bd;
  logic        flush;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_exc   (out_exc),
    .out_bd    (out_bd),
    .flush     (flush),
    .count     (count)
  );

  localparam logic [31:0] I_ADDU    = 32'h0085_1021;
  localparam logic [31:0] I_ADD     = 32'h0085_1020;
  localparam logic [31:0] I_OR      = 32'h0085_1025;
  localparam logic [31:0] I_BEQ     = 32'h1085_0004;
  localparam logic [31:0] I_RSVD    = 32'hFC00_0000;
  localparam logic [31:0] I_SYSCALL = 32'h0000_000C;
  localparam logic [31:0] I_BREAK   = 32'h0000_000D;
  localparam logic [31:0] I_MADD    = 32'h7085_0000;
  localparam logic [31:0] I_ERET    = 32'h4200_0018;

  // ADDU: rd=01 [24], am=01 [22], ab=01 [20], wb=01 [12], everything else 0
  localparam logic [30:0] CTRL_ADDU = 31'h0150_1000;

`ifdef DEC_SPECIAL2_EN
  localparam logic [1:0] MADD_EXC = 2'b00;
`else
  localparam logic [1:0] MADD_EXC = 2'b01;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample point 1 time unit after the edge
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  // Push one word into an empty queue, check its head view, then pop it
  task automatic one_entry(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [1:0] exc, input logic bd);
    step(1'b1, inst, pc, 1'b0, 1'b0);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_inst"}, out_inst, inst);
    check({tag, "_exc"}, 32'(out_exc), 32'(exc));
    check({tag, "_bd"}, 32'(out_bd), 32'(bd));
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check({tag, "_empty"}, 32'(count), 32'd0);
  endtask

  function automatic logic [31:0] fd_inst(input int i);
    return I_ADDU | (32'(i) << 11);
  endfunction

  function automatic logic [31:0] fd_pc(input int i);
    return 32'h200 + 32'(i) * 32'd4;
  endfunction

  initial begin
    int exp_q[$];
    int acc;
    int popped;
    int sz;
    int e;
    logic take;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_ctrl", 32'(out_ctrl), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_exc_bd", 32'({out_exc, out_bd}), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single decode
    step(1'b1, I_ADDU, 32'h100, 1'b0, 1'b0);
    check("sd_valid", 32'(out_valid), 32'd1);
    check("sd_pc", out_pc, 32'h100);
    check("sd_exc", 32'(out_exc), 32'd0);
    check("sd_bd", 32'(out_bd), 32'd0);
    check("sd_aluop", 32'(out_ctrl[30:26]), 32'd0);
    check("sd_ctrl", 32'(out_ctrl), 32'(CTRL_ADDU));
    check("sd_count", 32'(count), 32'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("sd_popped", 32'(count), 32'd0);

    // Fill to DEPTH with execute stalled
    for (int i = 0; i < 4; i++) begin
      step(1'b1, fd_inst(i), fd_pc(i), 1'b0, 1'b0);
      exp_q.push_back(i);
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_ready", 32'(in_ready), 32'd0);

    // Stream with execute always ready; fetch holds a word until taken
    acc    = 0;
    popped = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      sz = exp_q.size();
      if (acc >= 10 && sz == 0) break;
      check("fd_count", 32'(count), 32'(sz));
      check("fd_ready", 32'(in_ready), 32'(sz < 4));
      check("fd_valid", 32'(out_valid), 32'(sz > 0));
      if (sz > 0) begin
        check("fd_pc", out_pc, fd_pc(exp_q[0]));
        check("fd_inst", out_inst, fd_inst(exp_q[0]));
      end
      take = (acc < 10) && (sz < 4);
      step(acc < 10, fd_inst(4 + acc), fd_pc(4 + acc), 1'b1, 1'b0);
      if (sz > 0) begin
        e = exp_q.pop_front();
        popped++;
      end
      if (take) begin
        exp_q.push_back(4 + acc);
        acc++;
      end
    end
    check("fd_popped", 32'(popped), 32'd14);
    check("fd_end_count", 32'(count), 32'd0);

    // Delay slot: BEQ, idle, idle, ADD, OR
    step(1'b1, I_BEQ, 32'h300, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, I_ADD, 32'h304, 1'b0, 1'b0);
    step(1'b1, I_OR, 32'h308, 1'b0, 1'b0);
    check("ds_count", 32'(count), 32'd3);
    check("ds_bd0", 32'(out_bd), 32'd0);
    check("ds_pc0", out_pc, 32'h300);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("ds_bd1", 32'(out_bd), 32'd1);
    check("ds_pc1", out_pc, 32'h304);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("ds_bd2", 32'(out_bd), 32'd0);
    check("ds_pc2", out_pc, 32'h308);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    check("ds_empty", 32'(count), 32'd0);

    // Flush with a branch pending; the word offered during flush is dropped
    step(1'b1, I_BEQ, 32'h400, 1'b0, 1'b0);
    check("fl_pre", 32'(count), 32'd1);
    step(1'b1, I_ADD, 32'h404, 1'b0, 1'b1);
    check("fl_count", 32'(count), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    one_entry("fl_add", I_ADD, 32'h408, 2'b00, 1'b0);

    // Exception codes
    one_entry("ex_ri", I_RSVD, 32'h500, 2'b01, 1'b0);
    one_entry("ex_sys", I_SYSCALL, 32'h504, 2'b10, 1'b0);
    one_entry("ex_brk", I_BREAK, 32'h508, 2'b11, 1'b0);
    one_entry("ex_madd", I_MADD, 32'h50C, MADD_EXC, 1'b0);
    one_entry("ex_eret", I_ERET, 32'h510, 2'b00, 1'b0);

    // Asynchronous reset mid-stream with three entries queued
    step(1'b1, I_ADD, 32'h600, 1'b0, 1'b0);
    step(1'b1, I_ADD, 32'h604, 1'b0, 1'b0);
    step(1'b1, I_ADD, 32'h608, 1'b0, 1'b0);
    check("mr_pre", 32'(count), 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("mr_count", 32'(count), 32'd0);
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_ready", 32'(in_ready), 32'd1);
    check("mr_pc", out_pc, 32'd0);
    #4 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("mr_after", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
